// File: rtl/stream_serializer_if.sv
// rtl/stream_serializer_if.sv - beat-in / word-out handshake bundle for stream_serializer
interface stream_serializer_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  logic               valid_i;
  logic               ready_o;
  logic [N*WIDTH-1:0] data_i;
  logic               valid_o;
  logic               ready_i;
  logic [WIDTH-1:0]   data_o;

  modport slave (
    input  valid_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o
  );

  modport master (
    output valid_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o
  );
endinterface

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - splits N-lane beats into WIDTH-bit words, lane 0 first; STREAM_SERIALIZER_LAST_EN adds last_o
module stream_serializer #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  stream_serializer_if.slave bus
`ifdef STREAM_SERIALIZER_LAST_EN
  ,
  output logic               last_o
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t             state;
  logic [IW-1:0]      idx;
  logic [N*WIDTH-1:0] beat_q;
  logic               valid_q;
  logic               at_last;
  logic [WIDTH-1:0]   word;

  assign at_last     = (idx == LAST_IDX);
  // The last word's handshake frees the buffer, so the next beat can load in the same cycle.
  assign bus.ready_o = (state == IDLE) | (at_last & bus.ready_i);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = word;

`ifdef STREAM_SERIALIZER_LAST_EN
  assign last_o = valid_q & at_last;
`endif

  always_comb begin
    word = beat_q[WIDTH-1:0];
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) word = beat_q[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      idx     <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      state   <= IDLE;
      idx     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            beat_q  <= bus.data_i;
            idx     <= '0;
            state   <= BUSY;
            valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.ready_i) begin
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else if (bus.valid_i) begin
              beat_q <= bus.data_i;
              idx    <= '0;
            end else begin
              // Index back to 0 so the idle word is lane 0.
              idx     <= '0;
              state   <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          idx     <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - directed self-checking bench for stream_serializer (N=4 and N=1)
module tb_stream_serializer;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stream_serializer_if #(.WIDTH(8), .N(4)) bus4 ();
  stream_serializer_if #(.WIDTH(8), .N(1)) bus1 ();

`ifdef STREAM_SERIALIZER_LAST_EN
  logic last4;
  logic last1;
`endif

  stream_serializer #(.WIDTH(8), .N(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .bus   (bus4)
`ifdef STREAM_SERIALIZER_LAST_EN
    ,
    .last_o(last4)
`endif
  );

  stream_serializer #(.WIDTH(8), .N(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (1'b0),
    .bus   (bus1)
`ifdef STREAM_SERIALIZER_LAST_EN
    ,
    .last_o(last1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string tag, input logic v, input logic [7:0] d,
                         input logic r, input logic l);
    #2;
    check({tag, ".valid"}, 32'(bus4.valid_o), 32'(v));
    check({tag, ".data"},  32'(bus4.data_o),  32'(d));
    check({tag, ".ready"}, 32'(bus4.ready_o), 32'(r));
`ifdef STREAM_SERIALIZER_LAST_EN
    check({tag, ".last"},  32'(last4),        32'(l));
`else
    if (l === 1'bx) $display("unexpected x last flag in %s", tag);
`endif
  endtask

  task automatic expect1(input string tag, input logic v, input logic [7:0] d,
                         input logic r, input logic l);
    #2;
    check({tag, ".valid"}, 32'(bus1.valid_o), 32'(v));
    check({tag, ".data"},  32'(bus1.data_o),  32'(d));
    check({tag, ".ready"}, 32'(bus1.ready_o), 32'(r));
`ifdef STREAM_SERIALIZER_LAST_EN
    check({tag, ".last"},  32'(last1),        32'(l));
`else
    if (l === 1'bx) $display("unexpected x last flag in %s", tag);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w8 [8];
    w8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; clr = 1'b0;
    bus4.valid_i = 1'b0; bus4.data_i = '0; bus4.ready_i = 1'b1;
    bus1.valid_i = 1'b0; bus1.data_i = '0; bus1.ready_i = 1'b1;
    step();
    step();
    rst = 1'b0;
    expect4("reset", 1'b0, 8'h00, 1'b1, 1'b0);

    // Single beat, free-running consumer
    bus4.valid_i = 1'b1; bus4.data_i = 32'h44332211;
    expect4("r029_acc", 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    bus4.valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect4($sformatf("r029_w%0d", k), 1'b1, w8[4+k], k == 3, k == 3);
      step();
    end
    expect4("r029_idle", 1'b0, 8'h11, 1'b1, 1'b0);

    // Back-to-back beats, second loaded on the 0xDD handshake
    bus4.valid_i = 1'b1; bus4.data_i = 32'hDDCCBBAA;
    step();
    bus4.data_i = 32'h44332211;
    for (int k = 0; k < 8; k++) begin
      expect4($sformatf("r030_w%0d", k), 1'b1, w8[k], (k % 4) == 3, (k % 4) == 3);
      step();
      if (k == 3) bus4.valid_i = 1'b0;
    end
    expect4("r030_idle", 1'b0, 8'h11, 1'b1, 1'b0);

    // Downstream stall holds the first word
    bus4.valid_i = 1'b1; bus4.data_i = 32'h44332211;
    step();
    bus4.valid_i = 1'b0; bus4.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect4($sformatf("r031_hold%0d", k), 1'b1, 8'h11, 1'b0, 1'b0);
      step();
    end
    bus4.ready_i = 1'b1;
    expect4("r031_take", 1'b1, 8'h11, 1'b0, 1'b0);
    step();
    expect4("r031_w1", 1'b1, 8'h22, 1'b0, 1'b0);
    step();
    expect4("r031_w2", 1'b1, 8'h33, 1'b0, 1'b0);
    step();
    expect4("r031_w3", 1'b1, 8'h44, 1'b1, 1'b1);
    step();

    // Clear after 0x22 drops the rest of the beat
    bus4.valid_i = 1'b1; bus4.data_i = 32'h44332211;
    step();
    bus4.valid_i = 1'b0;
    expect4("r032_w0", 1'b1, 8'h11, 1'b0, 1'b0);
    step();
    expect4("r032_w1", 1'b1, 8'h22, 1'b0, 1'b0);
    step();
    clr = 1'b1;
    expect4("r032_clr", 1'b1, 8'h33, 1'b0, 1'b0);
    step();
    clr = 1'b0;
    expect4("r032_after", 1'b0, 8'h11, 1'b1, 1'b0);
    step();
    expect4("r032_after2", 1'b0, 8'h11, 1'b1, 1'b0);

    // Clear overrides an accept in IDLE
    bus4.valid_i = 1'b1; bus4.data_i = 32'h55667788; clr = 1'b1;
    expect4("clr_idle", 1'b0, 8'h11, 1'b1, 1'b0);
    step();
    clr = 1'b0; bus4.valid_i = 1'b0;
    expect4("clr_idle_after", 1'b0, 8'h11, 1'b1, 1'b0);

    // Reset with index 2
    bus4.valid_i = 1'b1; bus4.data_i = 32'h44332211;
    step();
    bus4.valid_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    expect4("r033_pre", 1'b1, 8'h33, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    expect4("r033_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    expect4("r033_rst2", 1'b0, 8'h00, 1'b1, 1'b0);

    // N=1: one-entry register with pass-through
    bus1.valid_i = 1'b1; bus1.data_i = 8'hA1; bus1.ready_i = 1'b1;
    expect1("n1_idle", 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    bus1.data_i = 8'hB2;
    expect1("n1_pass", 1'b1, 8'hA1, 1'b1, 1'b1);
    step();
    bus1.valid_i = 1'b0;
    expect1("n1_w2", 1'b1, 8'hB2, 1'b1, 1'b1);
    step();
    expect1("n1_empty", 1'b0, 8'hB2, 1'b1, 1'b0);
    bus1.valid_i = 1'b1; bus1.data_i = 8'hC3;
    step();
    bus1.ready_i = 1'b0; bus1.data_i = 8'hD4;
    expect1("n1_stall", 1'b1, 8'hC3, 1'b0, 1'b1);
    step();
    expect1("n1_stall2", 1'b1, 8'hC3, 1'b0, 1'b1);
    bus1.ready_i = 1'b1;
    expect1("n1_drain", 1'b1, 8'hC3, 1'b1, 1'b1);
    step();
    bus1.valid_i = 1'b0;
    expect1("n1_w4", 1'b1, 8'hD4, 1'b1, 1'b1);
    step();
    expect1("n1_end", 1'b0, 8'hD4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one output word (>=1).
REQ-002 SHALL have parameter N, default 4, words per input beat (>=1).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; one clock, synchronous active-high reset.
REQ-005 SHALL have port clr_i  input  1  synchronous clear; discards any held beat.
REQ-006 SHALL have port valid_i  input  1  upstream beat valid.
REQ-007 SHALL have port ready_o  output  1  upstream beat accepted when valid_i & ready_o.
REQ-008 SHALL have port data_i  input  N*WIDTH  beat; lane k = data_i[k*WIDTH +: WIDTH].
REQ-009 SHALL have port valid_o  output  1  downstream word valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts word when valid_o & ready_i.
REQ-011 SHALL have port data_o  output  WIDTH  current word.

Function
REQ-012 SHALL implement two states: IDLE (no beat held) and BUSY (beat held, words pending).
REQ-013 SHALL hold the accepted beat in an N*WIDTH buffer plus a lane index of max(1,$clog2(N)) bits.
REQ-014 IDLE: ready_o=1, valid_o=0; on valid_i, capture data_i, index:=0, go BUSY.
REQ-015 BUSY: valid_o=1, data_o = buffer lane[index]; lanes emitted in ascending order, lane 0 first.
REQ-016 BUSY, handshake and index<N-1: index:=index+1, stay BUSY.
REQ-017 BUSY, handshake and index==N-1: if valid_i, capture new beat, index:=0, stay BUSY; else go IDLE.
REQ-018 ready_o SHALL be (state==IDLE) | (index==N-1 & ready_i); combinational ready_i->ready_o path permitted.
REQ-019 Latency: first word valid the cycle after beat acceptance; sustained throughput one word per cycle, no bubble between beats.
REQ-020 valid_o and data_o SHALL stay stable while valid_o & ~ready_i (no retraction, no data change).
REQ-021 N==1: SHALL behave as a one-entry register with pass-through on full-and-draining.
REQ-022 data_o in IDLE SHALL be the buffer's lane 0 (don't-care to consumers, but deterministic).
REQ-023 clr_i SHALL force IDLE and index:=0 next cycle, overriding any simultaneous handshake; ready_o and valid_o are not gated by clr_i in the same cycle.

Reset
REQ-024 rst_i SHALL, on clock edge, force state IDLE, index 0, buffer 0; outputs then valid_o=0, ready_o=1, data_o=0.
REQ-025 Reset mid-beat SHALL drop remaining words; no word emitted after reset until a new beat is accepted.
REQ-026 rst_i SHALL take priority over clr_i and all handshakes.

Configuration
REQ-027 Macro STREAM_SERIALIZER_LAST_EN defined: SHALL add output port last_o (1 bit), high iff valid_o & index==N-1.
REQ-028 Macro STREAM_SERIALIZER_LAST_EN undefined: port last_o SHALL be absent; all other behaviour identical.

Verification
REQ-029 N=4, WIDTH=8, beat 0x44332211, ready_i=1 -> data_o 0x11,0x22,0x33,0x44 on 4 consecutive cycles, ready_o=0 cycles 1-3.
REQ-030 Two back-to-back beats 0xDDCCBBAA, 0x44332211, ready_i=1 -> 8 consecutive valid words, second beat accepted in the cycle 0xDD is taken.
REQ-031 Beat 0x44332211, ready_i low 3 cycles after first word -> data_o held at 0x11 with valid_o=1 throughout, then 0x22.
REQ-032 clr_i pulsed after 0x22 emitted -> next cycle valid_o=0, ready_o=1; 0x33,0x44 never appear.
REQ-033 rst_i asserted with index=2 -> next cycle valid_o=0, ready_o=1, data_o=0.
REQ-034 With STREAM_SERIALIZER_LAST_EN, N=4 -> last_o high only with word 0x44; N=1 -> last_o high with every word.
